// File: rtl/pad_frame_2d_if.sv
// Pixel stream bundle: one-clock valid pulse with pixel, line/frame markers and pad flag.
// The master drives every field; the slave never reads is_pad on the input side.
interface pad_frame_2d_if #(
    parameter int DW = 8
);
    logic          valid;
    logic [DW-1:0] pixel;
    logic          line_last;
    logic          frame_last;
    logic          is_pad;

    modport master (output valid, pixel, line_last, frame_last, is_pad);
    modport slave  (input  valid, pixel, line_last, frame_last);
endinterface

// File: rtl/pad_frame_2d.sv
// Captures one W x HIN frame, then replays it with a constant border on all four sides
// at the pixel tempo measured during capture (DEF_PERIOD when none was measured).
module pad_frame_2d #(
    parameter int            DW         = 8,
    parameter int            W          = 32,
    parameter int            HIN        = 24,
    parameter int            PAD_T      = 4,
    parameter int            PAD_B      = 4,
    parameter int            PAD_L      = 0,
    parameter int            PAD_R      = 0,
    parameter logic [DW-1:0] PAD_VAL    = '0,
    parameter int            DEF_PERIOD = 4
) (
    input  logic           clk,
    input  logic           srst,
    pad_frame_2d_if.slave  in_s,
    pad_frame_2d_if.master out_m,
    output logic           busy,
    output logic           err_size,
    output logic           err_overrun
);
    localparam int WO    = PAD_L + W + PAD_R;
    localparam int HO    = PAD_T + HIN + PAD_B;
    localparam int DEPTH = W * HIN;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 2);
    localparam int RW    = (HO > 1) ? $clog2(HO) : 1;
    localparam int CLW   = (WO > 1) ? $clog2(WO) : 1;

    localparam logic [CW-1:0]  CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_OK    = CW'(DEPTH - 1);
    localparam logic [CW-1:0]  CNT_SAT   = CW'(DEPTH + 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(HO - 1);
    localparam logic [CLW-1:0] COL_LAST  = CLW'(WO - 1);
    localparam logic [15:0]    DEF_P     = 16'(DEF_PERIOD);

    typedef enum logic {S_CAP, S_EMIT} state_t;

    state_t         state_q, state_d;
    logic [15:0]    icnt_q, icnt_d;
    logic [15:0]    period_meas_q, period_meas_d;
    logic           first_in_line_q, first_in_line_d;
    logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [15:0]    emit_period_q, emit_period_d;
    logic [15:0]    gen_cnt_q, gen_cnt_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CLW-1:0] col_q, col_d;
    logic [AW-1:0]  rd_addr_q, rd_addr_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_pixel_q, out_pixel_d;
    logic           out_line_last_q, out_line_last_d;
    logic           out_frame_last_q, out_frame_last_d;
    logic           out_is_pad_q, out_is_pad_d;
    logic           err_size_q, err_size_d;
    logic           err_overrun_q, err_overrun_d;

    logic [DW-1:0]  fb [DEPTH];

    logic cap_pix, wr_en, frame_ok, cap_done, tick, last_pos, emit_done, payload;

    assign cap_pix   = (state_q == S_CAP) && in_s.valid;
    assign wr_en     = cap_pix && (wr_cnt_q < CNT_FULL);
    assign frame_ok  = (wr_cnt_q == CNT_OK);
    assign cap_done  = cap_pix && in_s.frame_last && frame_ok;
    assign tick      = (state_q == S_EMIT) && (gen_cnt_q == emit_period_q - 16'd1);
    assign last_pos  = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign emit_done = tick && last_pos;
    assign payload   = (int'(row_q) >= PAD_T) && (int'(row_q) < PAD_T + HIN) &&
                       (int'(col_q) >= PAD_L) && (int'(col_q) < PAD_L + W);

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q          <= S_CAP;
            icnt_q           <= '0;
            period_meas_q    <= '0;
            first_in_line_q  <= 1'b1;
            wr_cnt_q         <= '0;
            emit_period_q    <= '0;
            gen_cnt_q        <= '0;
            row_q            <= '0;
            col_q            <= '0;
            rd_addr_q        <= '0;
            out_valid_q      <= 1'b0;
            out_pixel_q      <= '0;
            out_line_last_q  <= 1'b0;
            out_frame_last_q <= 1'b0;
            out_is_pad_q     <= 1'b0;
            err_size_q       <= 1'b0;
            err_overrun_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state_q          <= state_d;
            icnt_q           <= icnt_d;
            period_meas_q    <= period_meas_d;
            first_in_line_q  <= first_in_line_d;
            wr_cnt_q         <= wr_cnt_d;
            emit_period_q    <= emit_period_d;
            gen_cnt_q        <= gen_cnt_d;
            row_q            <= row_d;
            col_q            <= col_d;
            rd_addr_q        <= rd_addr_d;
            out_valid_q      <= out_valid_d;
            out_pixel_q      <= out_pixel_d;
            out_line_last_q  <= out_line_last_d;
            out_frame_last_q <= out_frame_last_d;
            out_is_pad_q     <= out_is_pad_d;
            err_size_q       <= err_size_d;
            err_overrun_q    <= err_overrun_d;
        end
    end

    // NOTE: the frame buffer has no reset; its contents are only read after a full capture.
    always_ff @(posedge clk) begin
        if (wr_en) fb[wr_cnt_q[AW-1:0]] <= in_s.pixel;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CAP:   if (cap_done)  state_d = S_EMIT;
            S_EMIT:  if (emit_done) state_d = S_CAP;
            default: state_d = S_CAP;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        icnt_d           = icnt_q;
        period_meas_d    = period_meas_q;
        first_in_line_d  = first_in_line_q;
        wr_cnt_d         = wr_cnt_q;
        emit_period_d    = emit_period_q;
        gen_cnt_d        = gen_cnt_q;
        row_d            = row_q;
        col_d            = col_q;
        rd_addr_d        = rd_addr_q;
        out_valid_d      = 1'b0;
        out_pixel_d      = out_pixel_q;
        out_line_last_d  = 1'b0;
        out_frame_last_d = 1'b0;
        out_is_pad_d     = 1'b0;
        err_size_d       = err_size_q;
        err_overrun_d    = err_overrun_q;

        if (state_q == S_CAP) begin
            icnt_d = (icnt_q == 16'hFFFF) ? icnt_q : icnt_q + 16'd1;
            if (in_s.valid) begin
                if (!first_in_line_q) period_meas_d = icnt_q;
                icnt_d          = 16'd1;
                first_in_line_d = in_s.line_last;
                wr_cnt_d        = (wr_cnt_q == CNT_SAT) ? wr_cnt_q : wr_cnt_q + CW'(1);
                if (in_s.frame_last) begin
                    if (frame_ok) begin
                        emit_period_d = (period_meas_d == 16'd0) ? DEF_P : period_meas_d;
                        gen_cnt_d     = '0;
                        row_d         = '0;
                        col_d         = '0;
                        rd_addr_d     = '0;
                    end else begin
                        err_size_d = 1'b1;
                        wr_cnt_d   = '0;
                    end
                end
            end
        end else begin
            if (in_s.valid) err_overrun_d = 1'b1;
            if (tick) begin
                gen_cnt_d        = '0;
                out_valid_d      = 1'b1;
                out_line_last_d  = (col_q == COL_LAST);
                out_frame_last_d = last_pos;
                if (payload) begin
                    out_pixel_d = fb[rd_addr_q];
                    rd_addr_d   = rd_addr_q + AW'(1);
                end else begin
                    out_pixel_d  = PAD_VAL;
                    out_is_pad_d = 1'b1;
                end
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CLW'(1);
                end
                if (last_pos) begin
                    wr_cnt_d        = '0;
                    first_in_line_d = 1'b1;
                end
            end else begin
                gen_cnt_d = gen_cnt_q + 16'd1;
            end
        end
    end

    assign out_m.valid      = out_valid_q;
    assign out_m.pixel      = out_pixel_q;
    assign out_m.line_last  = out_line_last_q;
    assign out_m.frame_last = out_frame_last_q;
    assign out_m.is_pad     = out_is_pad_q;
    assign busy             = (state_q == S_EMIT);
    assign err_size         = err_size_q;
    assign err_overrun      = err_overrun_q;
endmodule

// File: tb/tb_pad_frame_2d.sv
// Scoreboard bench for pad_frame_2d: three configurations (small padded, defaults, 1x1),
// expected outputs built from frame geometry and compared by an independent monitor.
`timescale 1ns/1ps
module tb_pad_frame_2d;
    localparam int GW[3]  = '{4, 32, 1};
    localparam int GH[3]  = '{2, 24, 1};
    localparam int GPT[3] = '{1, 4, 1};
    localparam int GPB[3] = '{1, 4, 0};
    localparam int GPL[3] = '{1, 0, 0};
    localparam int GPR[3] = '{1, 0, 0};
    localparam logic [7:0] GPV[3] = '{8'h00, 8'hFF, 8'h00};

    typedef struct {
        logic [7:0] pixel;
        logic       ll;
        logic       fl;
        logic       pad;
        int         period;
        bit         first;
    } exp_t;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    exp_t   exp_q[3][$];
    int     out_cnt[3];
    longint last_cyc[3];

    logic       iv[3], il[3], ifl[3];
    logic [7:0] ip[3];
    logic       ov[3], oll[3], ofl[3], opad[3];
    logic [7:0] op[3];
    logic [2:0] busy, err_size, err_overrun;

    pad_frame_2d_if #(.DW(8)) a_in(), a_out(), b_in(), b_out(), c_in(), c_out();

    assign a_in.valid = iv[0]; assign a_in.pixel = ip[0]; assign a_in.line_last = il[0];
    assign a_in.frame_last = ifl[0]; assign a_in.is_pad = 1'b0;
    assign b_in.valid = iv[1]; assign b_in.pixel = ip[1]; assign b_in.line_last = il[1];
    assign b_in.frame_last = ifl[1]; assign b_in.is_pad = 1'b0;
    assign c_in.valid = iv[2]; assign c_in.pixel = ip[2]; assign c_in.line_last = il[2];
    assign c_in.frame_last = ifl[2]; assign c_in.is_pad = 1'b0;

    assign ov[0] = a_out.valid; assign op[0] = a_out.pixel; assign oll[0] = a_out.line_last;
    assign ofl[0] = a_out.frame_last; assign opad[0] = a_out.is_pad;
    assign ov[1] = b_out.valid; assign op[1] = b_out.pixel; assign oll[1] = b_out.line_last;
    assign ofl[1] = b_out.frame_last; assign opad[1] = b_out.is_pad;
    assign ov[2] = c_out.valid; assign op[2] = c_out.pixel; assign oll[2] = c_out.line_last;
    assign ofl[2] = c_out.frame_last; assign opad[2] = c_out.is_pad;

    pad_frame_2d #(.DW(8), .W(4), .HIN(2), .PAD_T(1), .PAD_B(1), .PAD_L(1), .PAD_R(1),
                   .PAD_VAL(8'h00), .DEF_PERIOD(4)) dut_a (
        .clk(clk), .srst(srst), .in_s(a_in), .out_m(a_out),
        .busy(busy[0]), .err_size(err_size[0]), .err_overrun(err_overrun[0]));

    pad_frame_2d #(.DW(8), .PAD_VAL(8'hFF)) dut_b (
        .clk(clk), .srst(srst), .in_s(b_in), .out_m(b_out),
        .busy(busy[1]), .err_size(err_size[1]), .err_overrun(err_overrun[1]));

    pad_frame_2d #(.DW(8), .W(1), .HIN(1), .PAD_T(1), .PAD_B(0), .PAD_L(0), .PAD_R(0),
                   .PAD_VAL(8'h00), .DEF_PERIOD(4)) dut_c (
        .clk(clk), .srst(srst), .in_s(c_in), .out_m(c_out),
        .busy(busy[2]), .err_size(err_size[2]), .err_overrun(err_overrun[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: walk the padded output raster; payload positions index the captured frame.
    task automatic push_expected(input int k, input logic [7:0] pix[$], input int period);
        int wo, ho;
        wo = GPL[k] + GW[k] + GPR[k];
        ho = GPT[k] + GH[k] + GPB[k];
        for (int r = 0; r < ho; r++) begin
            for (int c = 0; c < wo; c++) begin
                exp_t e;
                bit   in_frame;
                in_frame = (r >= GPT[k]) && (r < GPT[k] + GH[k]) &&
                           (c >= GPL[k]) && (c < GPL[k] + GW[k]);
                e.pixel  = in_frame ? pix[(r - GPT[k]) * GW[k] + (c - GPL[k])] : GPV[k];
                e.pad    = !in_frame;
                e.ll     = (c == wo - 1);
                e.fl     = (c == wo - 1) && (r == ho - 1);
                e.period = period;
                e.first  = (r == 0) && (c == 0);
                exp_q[k].push_back(e);
            end
        end
    endtask

    task automatic send_frame(input int k, input logic [7:0] pix[$], input int n, input int gap);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            iv[k]  = 1'b1;
            ip[k]  = pix[i];
            il[k]  = (((i + 1) % GW[k]) == 0) || (i == n - 1);
            ifl[k] = (i == n - 1);
            @(posedge clk); #1;
            iv[k] = 1'b0; il[k] = 1'b0; ifl[k] = 1'b0;
            for (int j = 1; j < gap; j++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic rand_frame(input int n, output logic [7:0] pix[$]);
        pix = {};
        for (int i = 0; i < n; i++) pix.push_back(8'($urandom));
    endtask

    task automatic wait_drain(input int k, input int budget);
        int n;
        n = 0;
        while ((exp_q[k].size() != 0 || busy[k]) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check($sformatf("inst%0d_drain_timeout", k), (n >= budget), 1'b0);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse is matched against the head of that instance's queue.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (ov[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("inst%0d_unexpected_out", k), {opad[k], ofl[k], oll[k], op[k]}, 11'h7FF);
                end else begin
                    e = exp_q[k].pop_front();
                    check($sformatf("inst%0d_out%0d_pad_fl_ll_pix", k, out_cnt[k]),
                          {opad[k], ofl[k], oll[k], op[k]}, {e.pad, e.fl, e.ll, e.pixel});
                    if (!e.first)
                        check($sformatf("inst%0d_out%0d_spacing", k, out_cnt[k]),
                              64'(cyc - last_cyc[k]), 64'(e.period));
                end
                last_cyc[k] = cyc;
                out_cnt[k]++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, elapsed %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pix[$];
        int         base, n, gap;
        bit         seen;

        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; il[k] = 1'b0; ifl[k] = 1'b0; ip[k] = '0;
            out_cnt[k] = 0; last_cyc[k] = 0;
        end
        srst = 1'b1;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("inst%0d_reset_outputs", k),
                  {ov[k], op[k], oll[k], ofl[k], opad[k], busy[k], err_size[k], err_overrun[k]}, '0);

        // Small padded frame, pixels 1..8 at a 3-clock tempo.
        pix = {};
        for (int i = 1; i <= 8; i++) pix.push_back(8'(i));
        base = out_cnt[0];
        push_expected(0, pix, 3);
        send_frame(0, pix, 8, 3);
        wait_drain(0, 400);
        check("inst0_frame1_count", out_cnt[0] - base, 24);

        // 1x1 frame: no tempo is measured, so the default period applies.
        rand_frame(1, pix);
        push_expected(2, pix, 4);
        send_frame(2, pix, 1, 1);
        wait_drain(2, 100);

        // Default geometry with an all-ones border at a 2-clock tempo.
        rand_frame(768, pix);
        base = out_cnt[1];
        push_expected(1, pix, 2);
        send_frame(1, pix, 768, 2);
        wait_drain(1, 5000);
        check("inst1_frame_count", out_cnt[1] - base, 1024);

        // Short frame is discarded with err_size; a following good frame still replays.
        rand_frame(7, pix);
        send_frame(0, pix, 7, 2);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= busy[0];
        end
        check("inst0_short_frame_busy", seen, 1'b0);
        check("inst0_short_frame_err_size", err_size[0], 1'b1);
        gap = int'($urandom_range(1, 4));
        rand_frame(8, pix);
        push_expected(0, pix, gap);
        send_frame(0, pix, 8, gap);
        wait_drain(0, 400);
        check("inst0_err_size_sticky", err_size[0], 1'b1);
        check("inst0_err_overrun_clear", err_overrun[0], 1'b0);

        // Stray pixel during replay: flagged and dropped, replay unaffected.
        rand_frame(8, pix);
        push_expected(0, pix, 2);
        send_frame(0, pix, 8, 2);
        n = 0;
        while (!busy[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("inst0_emit_entry_timeout", (n >= 50), 1'b0);
        repeat (5) @(posedge clk);
        #1 iv[0] = 1'b1; ip[0] = 8'h5A;
        @(posedge clk); #1 iv[0] = 1'b0;
        check("inst0_err_overrun_set", err_overrun[0], 1'b1);
        wait_drain(0, 400);

        // Reset after the tenth output of a replay aborts it; a fresh frame replays from row 0.
        pix = {};
        for (int i = 1; i <= 8; i++) pix.push_back(8'(i));
        base = out_cnt[0];
        push_expected(0, pix, 3);
        send_frame(0, pix, 8, 3);
        n = 0;
        while (out_cnt[0] < base + 10 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("inst0_mid_emit_timeout", (n >= 400), 1'b0);
        #1 srst = 1'b1;
        exp_q[0].delete();
        @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        check("inst0_mid_emit_reset_outputs",
              {ov[0], op[0], oll[0], ofl[0], opad[0], busy[0], err_size[0], err_overrun[0]}, '0);
        check("inst0_mid_emit_outputs_seen", out_cnt[0] - base, 10);
        gap = int'($urandom_range(1, 4));
        rand_frame(8, pix);
        base = out_cnt[0];
        push_expected(0, pix, gap);
        send_frame(0, pix, 8, gap);
        wait_drain(0, 400);
        check("inst0_post_reset_count", out_cnt[0] - base, 24);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
